// File: rtl/pcm_encode.sv
// rtl/pcm_encode.sv - sequential A-law-style segment encoder, 13-bit sign-magnitude to 8-bit PCM code
module pcm_encode #(
    parameter logic [7:0] XOR_MASK = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [12:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SEARCH, OUT} state_t;

    state_t      state, state_n;
    logic        sign, sign_n;
    logic [11:0] mag, mag_n;
    logic [2:0]  seg, seg_n, seg_f;
    logic [7:0]  data_n;
    logic        valid_n;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Reaching segment 1 without a leading one means the sample belongs to segment 0.
    assign seg_f = (seg == 3'd1 && !mag[11]) ? 3'd0 : seg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sign      <= 1'b0;
            mag       <= 12'h000;
            seg       <= 3'd0;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            sign      <= sign_n;
            mag       <= mag_n;
            seg       <= seg_n;
            out_data  <= data_n;
            out_valid <= valid_n;
        end
    end

    always_comb begin
        state_n = state;
        sign_n  = sign;
        mag_n   = mag;
        seg_n   = seg;
        data_n  = out_data;
        valid_n = out_valid;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_n  = in_data[12];
                    mag_n   = in_data[11:0];
                    seg_n   = 3'd7;
                    state_n = SEARCH;
                end
            end
            SEARCH: begin
                if (mag[11] || seg == 3'd1) begin
                    data_n  = {sign, seg_f, mag[10:7]} ^ XOR_MASK;
                    valid_n = 1'b1;
                    state_n = OUT;
                end else begin
                    mag_n = {mag[10:0], 1'b0};
                    seg_n = seg - 3'd1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
